// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
// Shared definitions for the multi-port register file: default widths, the
// clear/ready FSM encoding, pipeline-wide constants and the parity helper.
// Optional feature macro used by the importing files: REGFILE_PARITY_EN.
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

  localparam int RegMpDataW = 32;
  localparam int RegMpAddrW = 5;

  // Widest register the parity helper accepts; narrower data is zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int RegMpMaxDataW = 128;

  typedef enum logic {
    RfStClear = 1'b0,
    RfStReady = 1'b1
  } rf_state_e;

  localparam logic [RegMpDataW-1:0] ZeroWord    = 32'h0000_0000;
  localparam logic [RegMpAddrW-1:0] NOPRegAddr  = 5'b00000;
  localparam logic                  WriteEnable = 1'b1;
  localparam logic                  ReadEnable  = 1'b1;

  // Even-parity bit: the value that makes the total number of ones even.
  function automatic logic even_parity(input logic [RegMpMaxDataW-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
// One combinational read port of regfile_mp. Selects, in priority order:
// zero (disabled port, address 0 or array still clearing), forwarded write data
// (highest-index matching write port), or the stored entry. With
// REGFILE_PARITY_EN defined it also flags a parity mismatch on stored reads.
//
// Ports:
//   ready_i     array is out of its clear sequence
//   re_i        read enable for this port
//   raddr_i     read address
//   we_i        write enables of all write ports
//   waddr_i     flattened write addresses, port i at [i*ADDR_W +: ADDR_W]
//   wdata_i     flattened write data, port i at [i*DATA_W +: DATA_W]
//   entry_i     stored array entry at raddr_i
//   entry_par_i stored parity bit at raddr_i (REGFILE_PARITY_EN only)
//   rdata_o     read data
//   rerr_o      parity error on this read
// -----------------------------------------------------------------------------
module regfile_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = RegMpDataW,
  parameter int ADDR_W = RegMpAddrW,
  parameter int NUM_WR = 2
) (
  input  logic                     ready_i,
  input  logic                     re_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0]        entry_i,
`ifdef REGFILE_PARITY_EN
  input  logic                     entry_par_i,
`endif
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     rerr_o
);

  logic              fwd_hit_s;
  logic [DATA_W-1:0] fwd_data_s;
  logic              zero_s;

  // Forwarding search; ascending loop so the highest-index match is kept.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_WR; i++) begin
      if ((we_i[i] == WriteEnable) && (waddr_i[i*ADDR_W +: ADDR_W] == raddr_i)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = wdata_i[i*DATA_W +: DATA_W];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  assign zero_s = (ready_i == 1'b0) || (re_i != ReadEnable) ||
                  (raddr_i == ADDR_W'(NOPRegAddr));

  // Output mux; address-0 reads win over forwarding so a dropped write to r0
  // never leaks through.
  always_comb begin
    rdata_o = DATA_W'(ZeroWord);
    rerr_o  = 1'b0;
    if (zero_s) begin
      rdata_o = DATA_W'(ZeroWord);
      rerr_o  = 1'b0;
    end else if (fwd_hit_s) begin
      rdata_o = fwd_data_s;
      rerr_o  = 1'b0;
    end else begin
      rdata_o = entry_i;
`ifdef REGFILE_PARITY_EN
      rerr_o  = (even_parity(RegMpMaxDataW'(entry_i)) != entry_par_i);
`else
      rerr_o  = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port general-purpose register file. NUM_RD combinational
// read ports with write-to-read forwarding, NUM_WR synchronous write ports
// (highest index wins on an address collision), register 0 hard-wired to zero.
// After reset a clear engine zeroes entries 1..DEPTH-1, one per cycle; ready
// rises the cycle after the last entry is cleared. While clearing, writes are
// ignored and all reads return zero.
// Optional feature macro: REGFILE_PARITY_EN adds a stored even-parity bit per
// entry, the par_flip error-injection input and live rerr reporting; without
// it rerr is tied low.
//
// Ports:
//   clk      clock, all state on posedge
//   rst      synchronous active-high reset, restarts the clear sequence
//   we       per-port write enable            [NUM_WR]
//   waddr    write addresses                  [NUM_WR*ADDR_W]
//   wdata    write data                       [NUM_WR*DATA_W]
//   re       per-port read enable             [NUM_RD]
//   raddr    read addresses                   [NUM_RD*ADDR_W]
//   par_flip invert stored parity on write    [NUM_WR] (REGFILE_PARITY_EN)
//   rdata    read data, combinational         [NUM_RD*DATA_W]
//   ready    registered, high once clearing is done
//   rerr     per-port parity error            [NUM_RD]
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = RegMpDataW,
  parameter int ADDR_W = RegMpAddrW,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
`ifdef REGFILE_PARITY_EN
  input  logic [NUM_WR-1:0]        par_flip,
`endif
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     ready,
  output logic [NUM_RD-1:0]        rerr
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] FirstClr = ADDR_W'(1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic              clr_we_s;
  logic              wr_allow_s;

  logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef REGFILE_PARITY_EN
  logic              par_q [DEPTH];
`endif

  // FSM state, clear pointer and ready flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RfStClear;
      clr_ptr_q <= FirstClr;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic: leave CLEAR once the last entry is being cleared.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RfStClear: begin
        if (clr_ptr_q == LastAddr) begin
          state_d = RfStReady;
        end else begin
          state_d = RfStClear;
        end
      end
      RfStReady: state_d = RfStReady;
      default:   state_d = RfStClear;
    endcase
  end

  // FSM outputs: clear strobe, pointer advance, ready next value, write gate.
  always_comb begin
    clr_we_s   = 1'b0;
    wr_allow_s = 1'b0;
    clr_ptr_d  = clr_ptr_q;
    ready_d    = 1'b0;
    case (state_q)
      RfStClear: begin
        clr_we_s   = 1'b1;
        wr_allow_s = 1'b0;
        clr_ptr_d  = clr_ptr_q + ADDR_W'(1);
        ready_d    = (clr_ptr_q == LastAddr);
      end
      RfStReady: begin
        clr_we_s   = 1'b0;
        wr_allow_s = 1'b1;
        clr_ptr_d  = clr_ptr_q;
        ready_d    = 1'b1;
      end
      default: begin
        clr_we_s   = 1'b0;
        wr_allow_s = 1'b0;
        clr_ptr_d  = clr_ptr_q;
        ready_d    = 1'b0;
      end
    endcase
  end

  // Array update: clear engine or user writes; the ascending port loop makes
  // the last (highest-index) non-blocking assignment win on a collision.
  always_ff @(posedge clk) begin
    if (!rst && clr_we_s) begin
      mem_q[clr_ptr_q] <= {DATA_W{1'b0}};
`ifdef REGFILE_PARITY_EN
      par_q[clr_ptr_q] <= 1'b0;
`endif
    end else if (!rst && wr_allow_s) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if ((we[i] == WriteEnable) &&
            (waddr[i*ADDR_W +: ADDR_W] != ADDR_W'(NOPRegAddr))) begin
          mem_q[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
`ifdef REGFILE_PARITY_EN
          par_q[waddr[i*ADDR_W +: ADDR_W]] <=
            even_parity(RegMpMaxDataW'(wdata[i*DATA_W +: DATA_W])) ^ par_flip[i];
`endif
        end
      end
    end
  end

  assign ready = ready_q;

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    assign ra_s = raddr[j*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_rd_port (
      .ready_i     (state_q == RfStReady),
      .re_i        (re[j]),
      .raddr_i     (ra_s),
      .we_i        (we),
      .waddr_i     (waddr),
      .wdata_i     (wdata),
      .entry_i     (mem_q[ra_s]),
`ifdef REGFILE_PARITY_EN
      .entry_par_i (par_q[ra_s]),
`endif
      .rdata_o     (rdata[j*DATA_W +: DATA_W]),
      .rerr_o      (rerr[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp with a behavioural model (array of entries,
// a clear-countdown and per-entry "parity was corrupted" flags) compared
// against the DUT on every negedge, plus literal expectations from hand
// calculation. Supports both builds (REGFILE_PARITY_EN defined or not).
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NW-1:0]  we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]  re;
  logic [NR*AW-1:0] raddr;
  logic [NW-1:0]  par_flip;
  logic [NR*DW-1:0] rdata;
  logic           ready;
  logic [NR-1:0]  rerr;

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (re),
    .raddr    (raddr),
`ifdef REGFILE_PARITY_EN
    .par_flip (par_flip),
`endif
    .rdata    (rdata),
    .ready    (ready),
    .rerr     (rerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [32];
  bit            m_bad [32];
  int            m_cnt = 0;
  bit            m_ready = 1'b0;
  bit            m_valid = 1'b0;

  // After reset every entry reads as zero once the countdown expires; while
  // counting, nothing is observable, so the model clears the whole array at once.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt   <= 31;
      m_ready <= 1'b0;
      m_valid <= 1'b1;
      for (int a = 0; a < 32; a++) begin
        m_mem[a] <= '0;
        m_bad[a] <= 1'b0;
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_ready <= 1'b1;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (we[i] && waddr[i*AW +: AW] != 5'd0) begin
          m_mem[waddr[i*AW +: AW]] <= wdata[i*DW +: DW];
`ifdef REGFILE_PARITY_EN
          m_bad[waddr[i*AW +: AW]] <= par_flip[i];
`else
          m_bad[waddr[i*AW +: AW]] <= 1'b0;
`endif
        end
      end
    end
  end

  function automatic logic [DW+1-1:0] exp_port(input int j);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit hit;
    a = raddr[j*AW +: AW];
    if (!m_ready || !re[j] || a == 5'd0) return '0;
    hit = 1'b0;
    d = '0;
    for (int i = 0; i < NW; i++)
      if (we[i] && waddr[i*AW +: AW] == a) begin
        hit = 1'b1;
        d = wdata[i*DW +: DW];
      end
    if (hit) return {1'b0, d};
    return {m_bad[a], m_mem[a]};
  endfunction

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready", 64'(ready), 64'(m_ready));
      for (int j = 0; j < NR; j++) begin
        logic [DW:0] e;
        e = exp_port(j);
        chk($sformatf("rdata%0d", j), 64'(rdata[j*DW +: DW]), 64'(e[DW-1:0]));
        chk($sformatf("rerr%0d", j), 64'(rerr[j]), 64'(e[DW]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic e, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = e;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input logic e, input logic [AW-1:0] a);
    re[p] = e;
    raddr[p*AW +: AW] = a;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(name, 64'(n), 64'd31);
  endtask

  initial begin
    rst = 1'b1; we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0; par_flip = '0;
    tick(); tick();
    rst = 1'b0;
    // Clearing: read and write attempts are both inert.
    set_rd(0, 1'b1, 5'd5);
    set_wr(0, 1'b1, 5'd12, 32'hAAAA_5555);
    #1;
    chk("ready_low_after_rst", 64'(ready), 64'd0);
    chk("clear_read_zero", 64'(rdata[31:0]), 64'h0);
    wait_ready("clear_len");
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_rd(0, 1'b1, 5'd12);
    #1 chk("clear_write_ignored", 64'(rdata[31:0]), 64'h0);

    // Forwarding, single port.
    tick();
    set_wr(0, 1'b1, 5'd7, 32'h1234_5678);
    set_rd(0, 1'b1, 5'd7);
    #1 chk("fwd_r7", 64'(rdata[31:0]), 64'h1234_5678);
    tick();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    #1 chk("stored_r7", 64'(rdata[31:0]), 64'h1234_5678);

    // Collision on r9: port 1 wins, both forwarded and stored.
    tick();
    set_wr(0, 1'b1, 5'd9, 32'h0000_1111);
    set_wr(1, 1'b1, 5'd9, 32'h0000_2222);
    set_rd(0, 1'b1, 5'd9);
    set_rd(1, 1'b1, 5'd9);
    #1 chk("fwd_r9_prio", 64'(rdata[31:0]), 64'h2222);
    tick();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_wr(1, 1'b0, 5'd0, 32'h0);
    #1 chk("stored_r9_prio", 64'(rdata[63:32]), 64'h2222);

    // r0 writes are dropped; disabled read port returns zero.
    tick();
    set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(0, 1'b1, 5'd0);
    #1 chk("r0_fwd_zero", 64'(rdata[31:0]), 64'h0);
    tick();
    set_wr(0, 1'b1, 5'd3, 32'h0000_0033);
    set_wr(1, 1'b0, 5'd0, 32'h0);
    #1 chk("r0_stored_zero", 64'(rdata[31:0]), 64'h0);
    tick();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_rd(1, 1'b0, 5'd3);
    set_rd(0, 1'b1, 5'd3);
    #1;
    chk("re1_off_zero", 64'(rdata[63:32]), 64'h0);
    chk("r3_port0", 64'(rdata[31:0]), 64'h33);

    // Reset clears pre-loaded content.
    tick();
    set_wr(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    set_wr(1, 1'b0, 5'd0, 32'h0);
    set_rd(0, 1'b1, 5'd5);
    #1 chk("r5_loaded", 64'(rdata[31:0]), 64'hDEAD_BEEF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_rd(0, 1'b1, 5'd7);
    #1 chk("clear_read_r7_zero", 64'(rdata[31:0]), 64'h0);
    wait_ready("clear_len_2");
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd7);
    #1;
    chk("r5_cleared", 64'(rdata[31:0]), 64'h0);
    chk("r7_cleared", 64'(rdata[63:32]), 64'h0);

    // Reset mid-clear at clr_ptr=10 restarts the full sequence.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("ready_low_restart", 64'(ready), 64'd0);
    wait_ready("clear_len_restart");

    // Parity error injection on r4.
    tick();
    set_wr(0, 1'b1, 5'd4, 32'h0000_0001);
    par_flip = 2'b01;
    tick();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    par_flip = 2'b00;
    set_rd(0, 1'b1, 5'd4);
    #1;
    chk("r4_data", 64'(rdata[31:0]), 64'h1);
`ifdef REGFILE_PARITY_EN
    chk("r4_rerr_injected", 64'(rerr[0]), 64'd1);
`else
    chk("r4_rerr_tied", 64'(rerr[0]), 64'd0);
`endif
    tick();
    set_wr(0, 1'b1, 5'd4, 32'h0000_0001);
    #1 chk("r4_fwd_no_rerr", 64'(rerr[0]), 64'd0);
    tick();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    #1 chk("r4_rerr_clean", 64'(rerr[0]), 64'd0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the OpenMIPS-style pipeline; successor to the 2-read/1-write register file.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with write-to-read forwarding and register 0 hard-wired to zero.
- Adds a post-reset sequential clear engine that zeroes every entry one per cycle, plus a ready flag that gates the pipeline.
- Sits between ID (reads) and WB (writes, including a second write port for dual-issue or HI/LO-style writeback).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (>=1)
- NUM_WR, 2, number of write ports (>=1)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_W  write addresses, port i at slice [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data, same slicing
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses
- rdata  out  NUM_RD*DATA_W  read data (combinational)
- ready  out  1  high once the clear sequence is complete
- rerr  out  NUM_RD  per-port parity error (see Optional Feature)

Behaviour:
- Reset: rst sampled high at posedge -> FSM=CLEAR, clr_ptr=1, ready=0. Reasserting rst at any time, including mid-CLEAR, restarts from clr_ptr=1.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle write 0 to entry clr_ptr, then clr_ptr++.
  - At clr_ptr==DEPTH-1: write that entry, move to READY, ready=1 from the next cycle.
  - Clear duration: DEPTH-1 cycles after the first cycle with rst low (31 cycles for defaults).
- Entry 0 is never stored; reads of address 0 always return 0, and writes to address 0 are dropped.
- In CLEAR:
  - All we are ignored.
  - All rdata = 0.
  - rerr = 0.
- Write in READY:
  - At posedge, each port i with we[i]=1 and waddr_i!=0 updates its entry.
  - Two ports writing the same address: the highest-index port wins.
- Read in READY, per port j, evaluated in priority order:
  1. rdata_j = 0 if re[j]=0 or raddr_j=0.
  2. Else, if any enabled write port has waddr==raddr_j, rdata_j = that wdata (highest-index match wins). This is forwarding: zero extra latency, and the array is updated at the next edge.
  3. Else rdata_j = stored entry.
- Read latency: 0 cycles (combinational). Write latency: 1 edge.
- ready is a registered output; reset value 0.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- With the macro defined:
  - Each entry stores an extra even-parity bit, computed on write and set to 0 during CLEAR.
  - Extra input port par_flip [NUM_WR] inverts the stored parity bit on that port's write (error injection).
  - rerr[j]=1 when port j returns a stored, non-forwarded, nonzero-address entry whose parity mismatches.
  - Forwarded reads and address-0 reads give rerr[j]=0.
- Without the macro:
  - No parity storage and no par_flip port.
  - rerr is tied to 0.

Decomposition:
- Shared package/defines.v additions:
  - RegMpDataW=32, RegMpAddrW=5
  - FSM encodings RfStClear=1'b0, RfStReady=1'b1
  - existing ZeroWord, NOPRegAddr, WriteEnable, ReadEnable
- One natural sub-module: regfile_rd_port, instantiated NUM_RD times via generate. It holds the per-port mux covering zero, forward-priority, array and parity check.

Test Plan:
- rst=1 for 2 cycles, then low -> ready=0 for exactly 31 cycles, ready=1 on cycle 32. Reading any address during CLEAR returns 0x00000000.
- Pre-load entry 5=0xDEADBEEF, pulse rst, wait for ready, read r5 -> 0x00000000. Separately, assert rst at clr_ptr=10 -> ready is delayed a further 31 cycles.
- Forwarding:
  - we[0]=1, waddr0=7, wdata0=0x12345678, raddr0=7, re0=1 in the same cycle -> rdata0=0x12345678 before the edge, and the array holds it after.
  - we[0] and we[1] both to r9 (0x1111 and 0x2222) -> rdata of r9 = 0x2222 before the edge and 0x2222 after.
- Write r0=0xFFFFFFFF on both ports -> reading r0 returns 0. With re1=0 and raddr1=3 -> rdata1=0.
- With REGFILE_PARITY_EN: write r4=0x1 with par_flip[0]=1, read r4 next cycle -> rerr0=1, rdata0=0x1. Rewrite r4 with par_flip=0 -> rerr0=0. Without the macro, rerr stays 0 throughout.
